// File: rtl/fetch_queue.sv
// Dual-packet fetch queue between F2 and the dual decoder; slot [1] is always the older packet.
// Optional FETCHQ_BYPASS_EN forwards incoming packets to dataF2 in the same cycle.
package fetch_queue_pkg;
   typedef struct packed {
      logic        valid;
      logic [31:0] pc;
      logic [31:0] instr;
      logic        pre_b;
      logic [31:0] pred_pc_jr;
   } fetch_data_t;
endpackage

module fetch_queue
   import fetch_queue_pkg::*;
#(
   parameter  int unsigned DEPTH = 8,
   localparam int unsigned AW    = $clog2(DEPTH)
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 flush,
   input  logic [1:0]           enq_valid,
   input  fetch_data_t [1:0]    enq_data,
   output logic                 enq_ready,
   input  logic [1:0]           deq_num,
   output fetch_data_t [1:0]    dataF2,
   output logic [AW:0]          count
);

   localparam int unsigned CW = AW + 1;

   logic [AW-1:0] head_q, head_d;
   logic [AW-1:0] tail_q, tail_d;
   logic [CW-1:0] count_q, count_d;
   fetch_data_t   mem_q [DEPTH];
   fetch_data_t   mem_d [DEPTH];

   logic          enq_fire_c;
   logic [1:0]    enq_num_c;
   logic [1:0]    deq_st_c;
   logic [1:0]    deq_in_c;
   logic [CW-1:0] avail_c;

   assign count = count_q;

   // Enqueue qualification and split of deq_num between stored and bypassed packets
   always_comb begin
      enq_ready  = (count_q <= CW'(DEPTH - 2));
      enq_fire_c = enq_ready && enq_valid[1];
      enq_num_c  = enq_fire_c ? (enq_valid[0] ? 2'd2 : 2'd1) : 2'd0;
`ifdef FETCHQ_BYPASS_EN
      avail_c  = count_q + CW'(enq_num_c);
      deq_st_c = (CW'(deq_num) > count_q) ? 2'(count_q) : deq_num;
      deq_in_c = deq_num - deq_st_c;
`else
      avail_c  = count_q;
      deq_st_c = deq_num;
      deq_in_c = 2'd0;
`endif
   end

   // Output view: stored entries, followed by incoming packets when bypassing
   always_comb begin
      dataF2[1] = mem_q[head_q];
      dataF2[0] = mem_q[head_q + AW'(1)];
`ifdef FETCHQ_BYPASS_EN
      if (count_q == CW'(0)) begin
         dataF2[1] = enq_data[1];
         dataF2[0] = enq_data[0];
      end else if (count_q == CW'(1)) begin
         dataF2[0] = enq_data[1];
      end
`endif
      dataF2[1].valid = (avail_c >= CW'(1));
      dataF2[0].valid = (avail_c >= CW'(2));
   end

   // Next-state: flush wins over enqueue and dequeue
   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      mem_d   = mem_q;
      if (flush) begin
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
      end else begin
         if (enq_fire_c) begin
            if (deq_in_c == 2'd0) begin
               mem_d[tail_q] = enq_data[1];
               if (enq_valid[0]) mem_d[tail_q + AW'(1)] = enq_data[0];
            end else if ((deq_in_c == 2'd1) && enq_valid[0]) begin
               mem_d[tail_q] = enq_data[0];
            end
         end
         head_d  = head_q + AW'(deq_st_c);
         tail_d  = tail_q + AW'(enq_num_c) - AW'(deq_in_c);
         count_d = count_q + CW'(enq_num_c) - CW'(deq_num);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   // Packet storage carries no reset; contents are qualified by count
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   a_enq_pattern : assert property (@(posedge clk) disable iff (reset)
      enq_valid != 2'b01);

   a_deq_legal : assert property (@(posedge clk) disable iff (reset || flush)
      (deq_num != 2'd3) && (CW'(deq_num) <= avail_c));

endmodule

// File: tb/tb_fetch_queue.sv
// Randomized bench for fetch_queue against a queue-based reference model.
module tb_fetch_queue;
   import fetch_queue_pkg::*;

   localparam int DEPTH = 8;

   logic              clk = 1'b0;
   logic              reset;
   logic              flush;
   logic [1:0]        enq_valid;
   fetch_data_t [1:0] enq_data;
   logic              enq_ready;
   logic [1:0]        deq_num;
   fetch_data_t [1:0] dataF2;
   logic [3:0]        count;

   fetch_data_t q[$];
   int n_pass   = 0;
   int n_checks = 0;

   fetch_queue #(.DEPTH(DEPTH)) dut (
      .clk(clk), .reset(reset), .flush(flush),
      .enq_valid(enq_valid), .enq_data(enq_data), .enq_ready(enq_ready),
      .deq_num(deq_num), .dataF2(dataF2), .count(count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   function automatic fetch_data_t pkt(input logic [31:0] pc);
      fetch_data_t p;
      p.valid      = 1'($urandom);
      p.pc         = pc;
      p.instr      = $urandom;
      p.pre_b      = 1'($urandom);
      p.pred_pc_jr = $urandom;
      return p;
   endfunction

   task automatic check_out(input fetch_data_t v[$]);
      fetch_data_t e;
      chk("valid1", 128'(dataF2[1].valid), 128'(v.size() >= 1));
      chk("valid0", 128'(dataF2[0].valid), 128'(v.size() >= 2));
      if (v.size() >= 1) begin
         e = v[0]; e.valid = 1'b1;
         chk("slot1", 128'(dataF2[1]), 128'(e));
      end
      if (v.size() >= 2) begin
         e = v[1]; e.valid = 1'b1;
         chk("slot0", 128'(dataF2[0]), 128'(e));
      end
   endtask

   // One cycle: drive, check outputs mid-cycle, then advance the model
   task automatic step(input logic [1:0] ev, input logic [1:0] dn, input logic fl,
                       input fetch_data_t d1, input fetch_data_t d0);
      fetch_data_t view[$];
      bit fire;
      @(negedge clk);
      enq_valid = ev; deq_num = dn; flush = fl;
      enq_data[1] = d1; enq_data[0] = d0;
      #1;
      fire = (q.size() <= DEPTH - 2) && ev[1];
      view = q;
      if (fire) begin
         view.push_back(d1);
         if (ev[0]) view.push_back(d0);
      end
      chk("count", 128'(count), 128'(q.size()));
      chk("enq_ready", 128'(enq_ready), 128'(q.size() <= DEPTH - 2));
`ifdef FETCHQ_BYPASS_EN
      check_out(view);
`else
      check_out(q);
`endif
      if (fl) q.delete();
      else begin
         q = view;
         repeat (int'(dn)) void'(q.pop_front());
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1; flush = 1'b0; enq_valid = 2'b00; deq_num = 2'd0;
      #1;
      q.delete();
      chk("rst_count", 128'(count), 128'(0));
      chk("rst_ready", 128'(enq_ready), 128'(1));
      chk("rst_valid1", 128'(dataF2[1].valid), 128'(0));
      chk("rst_valid0", 128'(dataF2[0].valid), 128'(0));
      @(negedge clk);
      reset = 1'b0;
   endtask

   initial begin
      reset = 1'b1; flush = 1'b0; enq_valid = 2'b00; deq_num = 2'd0;
      enq_data = '0;
      do_reset();

      // First pair visible next cycle in order
      step(2'b11, 2'd0, 1'b0, pkt(32'hBFC00000), pkt(32'hBFC00004));
      step(2'b00, 2'd0, 1'b0, pkt(0), pkt(0));
      chk("tp1_count", 128'(count), 128'(2));
      chk("tp1_pc1", 128'(dataF2[1].pc), 128'(32'hBFC00000));
      chk("tp1_pc0", 128'(dataF2[0].pc), 128'(32'hBFC00004));

      // Fill to DEPTH, then an extra pair must be dropped
      for (int i = 0; i < 3; i++)
         step(2'b11, 2'd0, 1'b0, pkt(32'h1000 + 32'(8 * i)), pkt(32'h1004 + 32'(8 * i)));
      step(2'b11, 2'd0, 1'b0, pkt(32'hDEAD0000), pkt(32'hDEAD0004));
      step(2'b00, 2'd0, 1'b0, pkt(0), pkt(0));
      chk("full_count", 128'(count), 128'(8));
      chk("full_ready", 128'(enq_ready), 128'(0));

      // Simultaneous deq 1 / enq 1 at count 3
      do_reset();
      step(2'b11, 2'd0, 1'b0, pkt(32'h100), pkt(32'h104));
      step(2'b10, 2'd0, 1'b0, pkt(32'h108), pkt(0));
      step(2'b10, 2'd1, 1'b0, pkt(32'h10C), pkt(0));
      step(2'b00, 2'd0, 1'b0, pkt(0), pkt(0));
      chk("c3_count", 128'(count), 128'(3));
      chk("c3_pc1", 128'(dataF2[1].pc), 128'(32'h104));

      // Pair written across the wrap point: head=4, tail=7, count=3
      do_reset();
      step(2'b11, 2'd0, 1'b0, pkt(32'h200), pkt(32'h204));
      step(2'b11, 2'd0, 1'b0, pkt(32'h208), pkt(32'h20C));
      step(2'b00, 2'd2, 1'b0, pkt(0), pkt(0));
      step(2'b00, 2'd2, 1'b0, pkt(0), pkt(0));
      step(2'b11, 2'd0, 1'b0, pkt(32'h210), pkt(32'h214));
      step(2'b10, 2'd0, 1'b0, pkt(32'h218), pkt(0));
      step(2'b11, 2'd2, 1'b0, pkt(32'h21C), pkt(32'h220));
      step(2'b00, 2'd0, 1'b0, pkt(0), pkt(0));
      chk("wrap_count", 128'(count), 128'(3));
      chk("wrap_pc1", 128'(dataF2[1].pc), 128'(32'h218));
      chk("wrap_pc0", 128'(dataF2[0].pc), 128'(32'h21C));

      // Flush beats simultaneous enqueue and dequeue
      do_reset();
      step(2'b11, 2'd0, 1'b0, pkt(32'h300), pkt(32'h304));
      step(2'b11, 2'd0, 1'b0, pkt(32'h308), pkt(32'h30C));
      step(2'b10, 2'd0, 1'b0, pkt(32'h310), pkt(0));
      step(2'b11, 2'd2, 1'b1, pkt(32'h314), pkt(32'h318));
      step(2'b00, 2'd0, 1'b0, pkt(0), pkt(0));
      chk("flush_count", 128'(count), 128'(0));
      chk("flush_ready", 128'(enq_ready), 128'(1));
      chk("flush_valid1", 128'(dataF2[1].valid), 128'(0));

`ifdef FETCHQ_BYPASS_EN
      // Bypassed pair consumed in the same cycle
      do_reset();
      step(2'b11, 2'd2, 1'b0, pkt(32'h400), pkt(32'h404));
      chk("byp_pc1", 128'(dataF2[1].pc), 128'(32'h400));
      chk("byp_pc0", 128'(dataF2[0].pc), 128'(32'h404));
      step(2'b00, 2'd0, 1'b0, pkt(0), pkt(0));
      chk("byp_count", 128'(count), 128'(0));
`endif

      // Random traffic with occasional flush and mid-run reset
      do_reset();
      for (int i = 0; i < 3000; i++) begin
         int r;
         int avail;
         logic [1:0] ev;
         logic [1:0] dn;
         r  = int'($urandom_range(0, 99));
         ev = (r < 20) ? 2'b00 : (r < 50) ? 2'b10 : 2'b11;
         avail = q.size();
`ifdef FETCHQ_BYPASS_EN
         if ((q.size() <= DEPTH - 2) && ev[1]) avail += ev[0] ? 2 : 1;
`endif
         dn = 2'($urandom_range(0, (avail < 2) ? avail : 2));
         if ($urandom_range(0, 499) == 0) do_reset();
         else step(ev, dn, ($urandom_range(0, 31) == 0), pkt($urandom), pkt($urandom));
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Dual-entry-per-cycle instruction buffer between the F2 fetch stage and the dual decoder.
- Decouples I-cache fetch bandwidth from decode/issue stalls.
- Accepts up to 2 fetch_data_t packets per cycle and presents the 2 oldest packets as dataF2[1:0].
- Slot [1] is always the older instruction, matching the decoder's slot-1-first convention.

Parameters:
- DEPTH, 8, number of entries; power of two, minimum 4.
- AW, $clog2(DEPTH), pointer width; derived, not overridable.

Ports:
- clk  input  1  core clock.
- reset  input  1  asynchronous, active-high reset.
- flush  input  1  pipeline redirect (branch mispredict, exception, eret); discards all entries.
- enq_valid  input  2  packet-valid per slot; [1] older. Legal patterns: 00, 10, 11 (01 illegal, assertion).
- enq_data  input  2 x $bits(fetch_data_t)  incoming F2 packets.
- enq_ready  output  1  high when free entries >= 2.
- deq_num  input  2  packets consumed by decode this cycle: 0, 1 or 2; must be <= count (assertion).
- dataF2  output  2 x $bits(fetch_data_t)  [1] = head, [0] = head+1; valid fields overridden per count.
- count  output  AW+1  current occupancy, 0..DEPTH.

Behaviour:
- Storage: circular array of DEPTH fetch_data_t entries; head pointer, tail pointer and count registers.
- Reset (async): head=0, tail=0, count=0, enq_ready=1, dataF2[1].valid=0, dataF2[0].valid=0. Array contents are don't-care.
- Enqueue fires when enq_ready && enq_valid[1]:
  - Writes enq_data[1] at tail.
  - If enq_valid[0], also writes enq_data[0] at tail+1.
  - tail advances by popcount(enq_valid), with pointer wrap modulo DEPTH.
  - If enq_ready=0, input is ignored; fetch must hold its data.
- Dequeue:
  - head advances by deq_num, modulo DEPTH.
  - Registered array contents are presented combinationally.
- Output valid:
  - dataF2[1].valid = (count>=1).
  - dataF2[0].valid = (count>=2).
  - All other fields pass through unmodified. Invalid slots may carry stale data.
- Count update: count_next = count + enq_num - deq_num, where enq_num=0 if enqueue did not fire. Simultaneous enqueue and dequeue are legal, including at count=DEPTH-2 with 2 in and 2 out.
- Latency: a packet enqueued in cycle N is visible on dataF2 in cycle N+1 (base build).
- Flush:
  - Synchronous; head=tail=0, count=0 at the next edge.
  - Enqueue and dequeue in the same cycle are ignored. Flush has priority.
  - enq_ready remains combinational from count, so it is 1 the cycle after flush.
- Wrap-around: a 2-packet enqueue with tail=DEPTH-1 writes entries DEPTH-1 and 0. Output reads head and (head+1) mod DEPTH.
- pre_b and pred_pc_jr are stored verbatim. The queue never splits or reorders a packet pair.
- Reset asserted mid-operation: immediate return to the reset state; no partial writes are observable after reset deasserts.

Optional Feature:
- FETCHQ_BYPASS_EN
- When defined and count==0 with enqueue firing:
  - enq_data is forwarded combinationally to dataF2 in the same cycle; valid follows enq_valid.
  - deq_num applies to the bypassed packets. Only packets not consumed are written: tail and count advance by enq_num - deq_num.
  - With count==1 and enq_valid=11: dataF2[1]=head and dataF2[0]=enq_data[1].
- Undefined: strict 1-cycle enqueue-to-output latency; no combinational enq-to-dataF2 path.

Test Plan:
- Reset then enqueue 11 with PCs 0xBFC00000/0xBFC00004, deq_num=0 -> next cycle count=2, dataF2[1].pc=0xBFC00000, dataF2[0].pc=0xBFC00004, both valid.
- Fill 8 entries with deq_num=0 -> count=8, enq_ready=0; a further enq of 11 is dropped and count stays 8.
- count=3, deq_num=1 and enq 10 -> count=3, head+1; dataF2[1] is the former second entry.
- tail=7 (head=4, count=3), enq 11 and deq 2 -> entries written at 7 and 0, head=6, count=3; dataF2 reads entries 6 and 7 correctly across wrap.
- count=5, flush=1 with enq 11 and deq_num=2 -> next cycle count=0, both valid=0, enq_ready=1.
- FETCHQ_BYPASS_EN, empty queue, enq 11 with deq_num=2 -> same-cycle dataF2 equals enq_data; next cycle count=0.
